// File: rtl/wbs_master_seq.sv
// Wishbone classic initiator: splits a 64-bit word request into one or two
// 32-bit single transfers, with a per-beat ack timeout.
module wbs_master_seq #(
  parameter int IDX_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic                 req_single,
  input  logic [31:0]          req_base,
  input  logic [IDX_WIDTH-1:0] req_idx,
  input  logic [63:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [63:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 wbs_cyc_o,
  output logic                 wbs_stb_o,
  output logic                 wbs_we_o,
  output logic [3:0]           wbs_sel_o,
  output logic [31:0]          wbs_adr_o,
  output logic [31:0]          wbs_dat_o,
  input  logic                 wbs_ack_i,
  input  logic [31:0]          wbs_dat_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_GAP, S_HI, S_RESP} state_t;

  state_t               state_q, state_d;
  logic                 cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]           sel_q, sel_d;
  logic [31:0]          adr_q, adr_d, dat_q, dat_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [63:0]          rdata_q, rdata_d;
  logic                 err_q, err_d, rsp_q, rsp_d, rdy_q, rdy_d;
  logic                 lwe_q, lwe_d, lsingle_q, lsingle_d;
  logic [31:0]          base_q, base_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [63:0]          wdata_q, wdata_d;

  // Address arithmetic wraps modulo 2^32; idx is zero-extended before the shift.
  function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                            input logic [IDX_WIDTH-1:0] idx,
                                            input logic single, input logic upper);
    logic [31:0] idx32;
    idx32 = 32'(idx);
    if (single) return base + idx32;
    return base + (idx32 << 1) + {31'd0, upper};
  endfunction

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    rsp_d     = 1'b0;
    lwe_d     = lwe_q;
    lsingle_d = lsingle_q;
    base_d    = base_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && rdy_q) begin
          lwe_d     = req_we;
          lsingle_d = req_single;
          base_d    = req_base;
          idx_d     = req_idx;
          wdata_d   = req_wdata;
          rdata_d   = '0;
          err_d     = 1'b0;
          cnt_d     = '0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = req_we;
          sel_d     = 4'hF;
          adr_d     = beat_addr(req_base, req_idx, req_single, 1'b0);
          dat_d     = req_we ? req_wdata[31:0] : 32'd0;
          state_d   = S_LO;
        end
      end
      S_LO, S_HI: begin
        if (wbs_ack_i) begin
          if (!lwe_q) begin
            if (state_q == S_LO) rdata_d[31:0]  = wbs_dat_i;
            else                 rdata_d[63:32] = wbs_dat_i;
          end
          stb_d = 1'b0;
          if (state_q == S_LO && !lsingle_q) begin
            state_d = S_GAP;
          end else begin
            state_d = S_RESP;
            rsp_d   = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
          rsp_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Entering RESP releases the bus entirely.
        if (state_d == S_RESP) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          sel_d = 4'h0;
          adr_d = '0;
          dat_d = '0;
        end
      end
      S_GAP: begin
        stb_d   = 1'b1;
        cnt_d   = '0;
        adr_d   = beat_addr(base_q, idx_q, 1'b0, 1'b1);
        dat_d   = lwe_q ? wdata_q[63:32] : 32'd0;
        state_d = S_HI;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      rsp_q     <= 1'b0;
      rdy_q     <= 1'b0;
      lwe_q     <= 1'b0;
      lsingle_q <= 1'b0;
      base_q    <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      rsp_q     <= rsp_d;
      rdy_q     <= rdy_d;
      lwe_q     <= lwe_d;
      lsingle_q <= lsingle_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = stb_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = sel_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wbs_master_seq.sv
// Directed bench for wbs_master_seq with a simple address-mapped Wishbone slave.
module tb_wbs_master_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_single = 1'b0;
  logic [31:0] req_base = '0;
  logic [15:0] req_idx = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic        wbs_ack_i = 1'b0;
  logic [31:0] wbs_dat_i = '0;

  wbs_master_seq #(.IDX_WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_single(req_single), .req_base(req_base), .req_idx(req_idx),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i)
  );

  always #5 clk = ~clk;

  // Slave knobs, written only by the stimulus process.
  logic        ack_en = 1'b1;
  logic        spur_on = 1'b0;
  logic [31:0] noack_adr = 32'hFFFF_FFFF;

  int          rsp_cnt = 0, stb_n = 0, gap_n = 0, beat_n = 0;
  logic [63:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic [31:0] log_adr [64];
  logic [31:0] log_dat [64];
  logic        log_we  [64];
  logic        want_ack;

  int n_chk = 0, n_pass = 0;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    case (a)
      32'h3200_000E: return 32'hDEAD_BEEF;
      32'h3200_000F: return 32'h1100_1010;
      32'h3400_0001: return 32'h0001_B801;
      default:       return 32'hA5A5_0000 ^ a;
    endcase
  endfunction

  assign want_ack = wbs_cyc_o && wbs_stb_o && ack_en && (wbs_adr_o != noack_adr);

  // Slave and monitor act on the falling edge; the DUT samples on the rising edge.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt    <= rsp_cnt + 1;
      last_rdata <= rsp_rdata;
      last_err   <= rsp_err;
    end
    if (wbs_stb_o) stb_n <= stb_n + 1;
    if (wbs_cyc_o && !wbs_stb_o) gap_n <= gap_n + 1;
    wbs_ack_i <= want_ack || (spur_on && !wbs_stb_o);
    wbs_dat_i <= slave_data(wbs_adr_o);
    if (want_ack) begin
      log_adr[6'(beat_n)] <= wbs_adr_o;
      log_dat[6'(beat_n)] <= wbs_dat_o;
      log_we[6'(beat_n)]  <= wbs_we_o;
      beat_n <= beat_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issues one request; lat counts cycles inclusively from the accept cycle to rsp_valid.
  task automatic do_req(input logic we, input logic single, input logic [31:0] base,
                        input logic [15:0] idx, input logic [63:0] wdata, output int lat);
    int r0;
    int guard;
    @(posedge clk); #2;
    req_we = we; req_single = single; req_base = base; req_idx = idx;
    req_wdata = wdata; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #2;
      guard++;
    end
    r0 = rsp_cnt;
    @(negedge clk); #1;
    lat = 1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    while (rsp_cnt == r0 && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b0, g0, s0, r0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_cyc", 64'(wbs_cyc_o), 64'd0);
    check("rst_stb", 64'(wbs_stb_o), 64'd0);
    check("rst_we", 64'(wbs_we_o), 64'd0);
    check("rst_sel", 64'(wbs_sel_o), 64'd0);
    check("rst_adr", 64'(wbs_adr_o), 64'd0);
    check("rst_dat", 64'(wbs_dat_o), 64'd0);
    check("rst_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("ready_after_rst", 64'(req_ready), 64'd1);

    // Double write
    b0 = beat_n; g0 = gap_n;
    do_req(1'b1, 1'b0, 32'h3100_0000, 16'd2, 64'h000B_CDEF_0123_4567, lat);
    check("t1_beats", 64'(beat_n - b0), 64'd2);
    check("t1_adr_lo", 64'(log_adr[6'(b0)]), 64'h3100_0004);
    check("t1_dat_lo", 64'(log_dat[6'(b0)]), 64'h0123_4567);
    check("t1_we_lo", 64'(log_we[6'(b0)]), 64'd1);
    check("t1_adr_hi", 64'(log_adr[6'(b0 + 1)]), 64'h3100_0005);
    check("t1_dat_hi", 64'(log_dat[6'(b0 + 1)]), 64'h000B_CDEF);
    check("t1_gap", 64'(gap_n - g0), 64'd1);
    check("t1_lat", 64'(lat), 64'd5);
    check("t1_err", 64'(last_err), 64'd0);
    check("t1_rdata", last_rdata, 64'd0);

    // Double read
    b0 = beat_n;
    do_req(1'b0, 1'b0, 32'h3200_0000, 16'd7, 64'd0, lat);
    check("t2_beats", 64'(beat_n - b0), 64'd2);
    check("t2_adr_lo", 64'(log_adr[6'(b0)]), 64'h3200_000E);
    check("t2_adr_hi", 64'(log_adr[6'(b0 + 1)]), 64'h3200_000F);
    check("t2_we", 64'(log_we[6'(b0)]), 64'd0);
    check("t2_rdata", last_rdata, 64'h1100_1010_DEAD_BEEF);
    check("t2_lat", 64'(lat), 64'd5);

    // Single read
    b0 = beat_n;
    do_req(1'b0, 1'b1, 32'h3400_0000, 16'd1, 64'd0, lat);
    check("t3_beats", 64'(beat_n - b0), 64'd1);
    check("t3_adr", 64'(log_adr[6'(b0)]), 64'h3400_0001);
    check("t3_rdata", last_rdata, 64'h0000_0000_0001_B801);
    check("t3_lat", 64'(lat), 64'd3);

    // Timeout on the lower beat of a double read
    ack_en = 1'b0;
    b0 = beat_n; s0 = stb_n; g0 = gap_n;
    do_req(1'b0, 1'b0, 32'h3200_0000, 16'd7, 64'd0, lat);
    ack_en = 1'b1;
    check("t4_stb_cycles", 64'(stb_n - s0), 64'd4);
    check("t4_no_beats", 64'(beat_n - b0), 64'd0);
    check("t4_no_gap", 64'(gap_n - g0), 64'd0);
    check("t4_err", 64'(last_err), 64'd1);
    check("t4_rdata", last_rdata, 64'd0);
    check("t4_lat", 64'(lat), 64'd6);
    do_req(1'b0, 1'b1, 32'h3400_0000, 16'd1, 64'd0, lat);
    check("t4_next_err", 64'(last_err), 64'd0);
    check("t4_next_rdata", last_rdata, 64'h0000_0000_0001_B801);
    check("t4_next_lat", 64'(lat), 64'd3);

    // Spurious acks while idle and between beats
    spur_on = 1'b1;
    r0 = rsp_cnt; s0 = stb_n;
    repeat (5) @(posedge clk);
    #2;
    check("t5_idle_rsp", 64'(rsp_cnt - r0), 64'd0);
    check("t5_idle_stb", 64'(stb_n - s0), 64'd0);
    check("t5_idle_ready", 64'(req_ready), 64'd1);
    b0 = beat_n; g0 = gap_n; r0 = rsp_cnt;
    do_req(1'b1, 1'b0, 32'h3100_0000, 16'd3, 64'h1111_2222_3333_4444, lat);
    repeat (3) @(posedge clk);
    #2;
    check("t5_beats", 64'(beat_n - b0), 64'd2);
    check("t5_gap", 64'(gap_n - g0), 64'd1);
    check("t5_lat", 64'(lat), 64'd5);
    check("t5_one_rsp", 64'(rsp_cnt - r0), 64'd1);
    check("t5_adr_hi", 64'(log_adr[6'(b0 + 1)]), 64'h3100_0007);
    spur_on = 1'b0;

    // req_valid held through a busy transfer: second accept only once idle again
    r0 = rsp_cnt; b0 = beat_n;
    req_we = 1'b0; req_single = 1'b1; req_base = 32'h3400_0000; req_idx = 16'd1;
    req_valid = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("t5_busy_ready", 64'(req_ready), 64'd0);
    check("t5_first_rsp", 64'(rsp_cnt - r0), 64'd1);
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("t5_held_rsps", 64'(rsp_cnt - r0), 64'd2);
    check("t5_held_beats", 64'(beat_n - b0), 64'd2);

    // Reset asserted while the upper beat waits for ack
    noack_adr = 32'h3100_0011;
    req_we = 1'b1; req_single = 1'b0; req_base = 32'h3100_0000; req_idx = 16'd8;
    req_wdata = 64'hCAFE_F00D_5555_AAAA; req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("t6_hi_stb", 64'(wbs_stb_o), 64'd1);
    check("t6_hi_adr", 64'(wbs_adr_o), 64'h3100_0011);
    r0 = rsp_cnt;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_cyc", 64'(wbs_cyc_o), 64'd0);
    check("t6_rst_stb", 64'(wbs_stb_o), 64'd0);
    check("t6_rst_adr", 64'(wbs_adr_o), 64'd0);
    check("t6_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    noack_adr = 32'hFFFF_FFFF;
    @(posedge clk); #2;
    check("t6_ready", 64'(req_ready), 64'd1);
    check("t6_no_rsp", 64'(rsp_cnt - r0), 64'd0);

    // Address wrap modulo 2^32
    b0 = beat_n;
    do_req(1'b1, 1'b0, 32'hFFFF_FFF0, 16'hFFFF, 64'h89AB_CDEF_7654_3210, lat);
    check("t6_wrap_beats", 64'(beat_n - b0), 64'd2);
    check("t6_wrap_adr_lo", 64'(log_adr[6'(b0)]), 64'h0001_FFEE);
    check("t6_wrap_adr_hi", 64'(log_adr[6'(b0 + 1)]), 64'h0001_FFEF);
    check("t6_wrap_dat_hi", 64'(log_dat[6'(b0 + 1)]), 64'h89AB_CDEF);
    check("t6_wrap_err", 64'(last_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
